// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Optional registered status flags are enabled by defining ALU_PIPE_FLAGS_EN.
module alu_pipe #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     inp1,
    input  logic [N-1:0]     inp2,
    input  logic [2:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   outp,
    output logic             busy
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf
`endif
);

    // Shift counts at or above 2N flush every bit out of the result.
    localparam logic [N:0] LP_SHL_LIM = (N+1)'(2*N);

    logic             r_s1_v;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [2:0]       r_op;
    logic             r_s2_v;
    logic [2*N-1:0]   r_outp;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [N:0]       w_sum;
    logic [N:0]       w_diff;
    logic [2*N-1:0]   w_res;

    assign w_s2_load = r_s1_v && (!r_s2_v || out_ready);
    assign in_ready  = reset && (!r_s1_v || w_s2_load);
    assign w_s1_load = in_valid && in_ready;
    assign out_valid = r_s2_v;
    assign outp      = r_outp;
    assign busy      = r_s1_v || r_s2_v;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // Result datapath evaluated from the stage-1 registers.
    always_comb begin
        w_res = {(2*N){1'b0}};
        case (r_op)
            3'd0: w_res = {{(N-1){1'b0}}, w_sum};
            3'd1: w_res = {{(N-1){w_diff[N]}}, w_diff};
            3'd2: w_res = {{N{1'b0}}, r_a} * {{N{1'b0}}, r_b};
            3'd3: w_res = {{N{1'b0}}, r_a & r_b};
            3'd4: w_res = {{N{1'b0}}, r_a | r_b};
            3'd5: w_res = {{N{1'b0}}, r_a ^ r_b};
            3'd6: begin
                if ({1'b0, r_b} >= LP_SHL_LIM) begin
                    w_res = {(2*N){1'b0}};
                end else begin
                    w_res = {{N{1'b0}}, r_a} << r_b;
                end
            end
            3'd7: w_res = {{(2*N-3){1'b0}}, (r_a < r_b), (r_a == r_b), (r_a > r_b)};
            default: w_res = {(2*N){1'b0}};
        endcase
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic r_zero;
    logic r_carry;
    logic r_ovf;
    logic w_carry;
    logic w_ovf;

    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign flag_ovf   = r_ovf;

    // Carry/borrow and signed overflow apply only to ADD and SUB.
    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            3'd0: begin
                w_carry = w_sum[N];
                w_ovf   = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
            end
            3'd1: begin
                w_carry = (r_a < r_b);
                w_ovf   = (r_a[N-1] != r_b[N-1]) && (w_diff[N-1] != r_a[N-1]);
            end
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end
`endif

    // Stage 1: operand capture and its valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_v <= 1'b0;
            r_a    <= {N{1'b0}};
            r_b    <= {N{1'b0}};
            r_op   <= 3'd0;
        end else begin
            if (!r_s1_v || w_s2_load) begin
                r_s1_v <= w_s1_load;
            end
            if (w_s1_load) begin
                r_a  <= inp1;
                r_b  <= inp2;
                r_op <= op_code;
            end
        end
    end

    // Stage 2: result register; holds its value whenever nothing new advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_v  <= 1'b0;
            r_outp  <= {(2*N){1'b0}};
`ifdef ALU_PIPE_FLAGS_EN
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (!r_s2_v || out_ready) begin
                r_s2_v <= r_s1_v;
            end
            if (w_s2_load) begin
                r_outp  <= w_res;
`ifdef ALU_PIPE_FLAGS_EN
                r_zero  <= (w_res == {(2*N){1'b0}});
                r_carry <= w_carry;
                r_ovf   <= w_ovf;
`endif
            end
        end
    end

endmodule
